// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the 5-stage pipeline datapath and its hazard/sequencing controller.
// The pipeline drives hazard status as master; the controller returns enables, flushes and counters as slave.
interface pipe_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic             idex_memread;
    logic [4:0]       idex_rd;
    logic [4:0]       ifid_rs1;
    logic [4:0]       ifid_rs2;
    logic             ex_br_taken;
    logic             mem_req;
    logic             mem_ready;

    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_write;
    logic             idex_flush;
    logic             exmem_write;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output idex_memread, idex_rd, ifid_rs1, ifid_rs2, ex_br_taken, mem_req, mem_ready,
        input  pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write,
               mem_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  idex_memread, idex_rd, ifid_rs1, ifid_rs2, ex_br_taken, mem_req, mem_ready,
        output pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write,
               mem_err, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller: load-use bubbles, taken-branch flushes, data-memory wait states
// with a timeout, and saturating stall/flush performance counters.
module pipe_hazard_ctrl #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned MEM_TIMEOUT = 64
) (
    input logic              clk,
    input logic              reset,
    pipe_hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    // wait_cnt holds the number of wait cycles already completed, so the timeout
    // fires on the edge that ends wait cycle number MEM_TIMEOUT.
    localparam logic [7:0] LAST_WAIT = 8'(MEM_TIMEOUT - 1);

    state_t           state, state_nxt;
    logic [7:0]       wait_cnt, wait_cnt_nxt;
    logic             mem_err_r, mem_err_nxt;
    logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r;

    logic lu, mw, br_applied;
    logic pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write;

    always_comb begin
        lu = hz.idex_memread && (hz.idex_rd != 5'd0) &&
             ((hz.idex_rd == hz.ifid_rs1) || (hz.idex_rd == hz.ifid_rs2));
        mw = hz.mem_req && !hz.mem_ready && (state != ERR);
    end

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_write  = 1'b1;
        idex_flush  = 1'b0;
        exmem_write = 1'b1;
        br_applied  = 1'b0;
        if (!reset) begin
            if (mw) begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_write  = 1'b0;
                exmem_write = 1'b0;
            end else if (hz.ex_br_taken) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                br_applied = 1'b1;
            end else if (lu) begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                idex_flush = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        mem_err_nxt  = mem_err_r;
        case (state)
            RUN: begin
                if (mw) begin
                    if (LAST_WAIT == 8'd0) begin
                        state_nxt    = ERR;
                        wait_cnt_nxt = '0;
                        mem_err_nxt  = 1'b1;
                    end else begin
                        state_nxt    = MEM_WAIT;
                        wait_cnt_nxt = 8'd1;
                    end
                end
            end
            MEM_WAIT: begin
                if (!mw) begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = '0;
                end else if (wait_cnt >= LAST_WAIT) begin
                    state_nxt    = ERR;
                    wait_cnt_nxt = '0;
                    mem_err_nxt  = 1'b1;
                end else begin
                    wait_cnt_nxt = wait_cnt + 8'd1;
                end
            end
            ERR: begin
                state_nxt    = RUN;
                wait_cnt_nxt = '0;
            end
            default: begin
                state_nxt    = RUN;
                wait_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RUN;
            wait_cnt  <= '0;
            mem_err_r <= 1'b0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_cnt_nxt;
            mem_err_r <= mem_err_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_r <= '0;
            flush_cnt_r <= '0;
        end else begin
            if (!pc_write && (stall_cnt_r != '1))
                stall_cnt_r <= stall_cnt_r + 1'b1;
            if (br_applied && (flush_cnt_r != '1))
                flush_cnt_r <= flush_cnt_r + 1'b1;
        end
    end

    assign hz.pc_write    = pc_write;
    assign hz.ifid_write  = ifid_write;
    assign hz.ifid_flush  = ifid_flush;
    assign hz.idex_write  = idex_write;
    assign hz.idex_flush  = idex_flush;
    assign hz.exmem_write = exmem_write;
    assign hz.mem_err     = mem_err_r;
    assign hz.stall_cnt   = stall_cnt_r;
    assign hz.flush_cnt   = flush_cnt_r;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (timeout 4 / 16-bit counters, timeout 1 / 2-bit counters)
// share directed stimulus and are checked every cycle against a behavioural model plus literal expectations.
module tb_pipe_hazard_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       memread = 1'b0;
    logic [4:0] rd = '0;
    logic [4:0] rs1 = '0;
    logic [4:0] rs2 = '0;
    logic       br = 1'b0;
    logic       mem_req = 1'b0;
    logic       mem_ready = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.CNT_W(16)) ifa ();
    pipe_hazard_ctrl_if #(.CNT_W(2))  ifb ();

    assign ifa.idex_memread = memread;
    assign ifa.idex_rd      = rd;
    assign ifa.ifid_rs1     = rs1;
    assign ifa.ifid_rs2     = rs2;
    assign ifa.ex_br_taken  = br;
    assign ifa.mem_req      = mem_req;
    assign ifa.mem_ready    = mem_ready;
    assign ifb.idex_memread = memread;
    assign ifb.idex_rd      = rd;
    assign ifb.ifid_rs1     = rs1;
    assign ifb.ifid_rs2     = rs2;
    assign ifb.ex_br_taken  = br;
    assign ifb.mem_req      = mem_req;
    assign ifb.mem_ready    = mem_ready;

    pipe_hazard_ctrl #(.CNT_W(16), .MEM_TIMEOUT(4)) dut_a (.clk(clk), .reset(reset), .hz(ifa));
    pipe_hazard_ctrl #(.CNT_W(2),  .MEM_TIMEOUT(1)) dut_b (.clk(clk), .reset(reset), .hz(ifb));

    // Control vector order: {pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write}
    logic [5:0]  act_ctl   [2];
    logic        act_err   [2];
    logic [31:0] act_stall [2];
    logic [31:0] act_flush [2];

    assign act_ctl[0]   = {ifa.pc_write, ifa.ifid_write, ifa.ifid_flush,
                           ifa.idex_write, ifa.idex_flush, ifa.exmem_write};
    assign act_ctl[1]   = {ifb.pc_write, ifb.ifid_write, ifb.ifid_flush,
                           ifb.idex_write, ifb.idex_flush, ifb.exmem_write};
    assign act_err[0]   = ifa.mem_err;
    assign act_err[1]   = ifb.mem_err;
    assign act_stall[0] = {16'b0, ifa.stall_cnt};
    assign act_stall[1] = {30'b0, ifb.stall_cnt};
    assign act_flush[0] = {16'b0, ifa.flush_cnt};
    assign act_flush[1] = {30'b0, ifb.flush_cnt};

    // Behavioural model: count consecutive blocked cycles; after TIMEOUT of them the
    // memory is treated as ready for one cycle and the error flag latches.
    int timeout_of [2] = '{4, 1};
    int width_of   [2] = '{16, 2};
    int m_waited   [2] = '{0, 0};
    bit m_release  [2] = '{1'b0, 1'b0};
    bit m_err      [2] = '{1'b0, 1'b0};
    int m_stall    [2] = '{0, 0};
    int m_flush    [2] = '{0, 0};

    function automatic bit blocked(int i);
        return mem_req && !mem_ready && !m_release[i];
    endfunction

    function automatic logic [5:0] exp_ctl(int i);
        bit load_use;
        load_use = memread && (rd != 5'd0) && (rd == rs1 || rd == rs2);
        if (reset)       return 6'b110101;
        if (blocked(i))  return 6'b000000;
        if (br)          return 6'b111111;
        if (load_use)    return 6'b000111;
        return 6'b110101;
    endfunction

    function automatic int sat(int total, int w);
        int mx;
        mx = (1 << w) - 1;
        return (total > mx) ? mx : total;
    endfunction

    always @(posedge clk or posedge reset) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_waited[i]  = 0;
                m_release[i] = 1'b0;
                m_err[i]     = 1'b0;
                m_stall[i]   = 0;
                m_flush[i]   = 0;
            end else begin
                if (exp_ctl(i) == 6'b000000 || exp_ctl(i) == 6'b000111) m_stall[i]++;
                if (br && !blocked(i)) m_flush[i]++;
                if (blocked(i)) begin
                    m_waited[i]++;
                    if (m_waited[i] >= timeout_of[i]) begin
                        m_waited[i]  = 0;
                        m_release[i] = 1'b1;
                        m_err[i]     = 1'b1;
                    end
                end else begin
                    m_waited[i]  = 0;
                    m_release[i] = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("model ctl[%0d]", i), int'(act_ctl[i]), int'(exp_ctl(i)));
            chk($sformatf("model mem_err[%0d]", i), int'(act_err[i]), int'(m_err[i]));
            chk($sformatf("model stall_cnt[%0d]", i), int'(act_stall[i]), sat(m_stall[i], width_of[i]));
            chk($sformatf("model flush_cnt[%0d]", i), int'(act_flush[i]), sat(m_flush[i], width_of[i]));
        end
    end

    // One cycle: apply inputs just after the edge, return just after the falling edge.
    task automatic cyc(input bit rs, input bit mr, input logic [4:0] r, input logic [4:0] s1,
                       input logic [4:0] s2, input bit b, input bit rq, input bit ry);
        @(posedge clk);
        #1;
        reset = rs; memread = mr; rd = r; rs1 = s1; rs2 = s2;
        br = b; mem_req = rq; mem_ready = ry;
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // reset held with a load-use pattern present: enables stay high
        cyc(1'b1, 1'b1, 5'd5, 5'd5, 5'd1, 1'b0, 1'b0, 1'b0);
        chk("reset pc_write", int'(ifa.pc_write), 1);
        chk("reset idex_flush", int'(ifa.idex_flush), 0);
        chk("reset stall_cnt", int'(ifa.stall_cnt), 0);
        idle();
        chk("idle ctl", int'(act_ctl[0]), 'b110101);

        // ld x5 ; add x6,x5,x1
        cyc(1'b0, 1'b1, 5'd5, 5'd5, 5'd1, 1'b0, 1'b0, 1'b0);
        chk("lu pc_write", int'(ifa.pc_write), 0);
        chk("lu ifid_write", int'(ifa.ifid_write), 0);
        chk("lu idex_flush", int'(ifa.idex_flush), 1);
        chk("lu exmem_write", int'(ifa.exmem_write), 1);
        idle();
        chk("lu stall_cnt", int'(ifa.stall_cnt), 1);

        // x0 destination never stalls
        cyc(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("x0 ctl", int'(act_ctl[0]), 'b110101);

        // taken branch beats load-use
        cyc(1'b0, 1'b1, 5'd5, 5'd5, 5'd1, 1'b1, 1'b0, 1'b0);
        chk("br ifid_flush", int'(ifa.ifid_flush), 1);
        chk("br idex_flush", int'(ifa.idex_flush), 1);
        chk("br pc_write", int'(ifa.pc_write), 1);
        idle();
        chk("br flush_cnt", int'(ifa.flush_cnt), 1);
        chk("br stall_cnt", int'(ifa.stall_cnt), 1);

        // three wait cycles then ready; branch during a freeze is ignored
        cyc(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        chk("mw freeze", int'(act_ctl[0]), 0);
        cyc(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
        chk("mw br ignored", int'(ifa.ifid_flush), 0);
        cyc(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
        chk("mw ready pc_write", int'(ifa.pc_write), 1);
        idle();
        chk("mw stall_cnt", int'(ifa.stall_cnt), 4);
        chk("mw flush_cnt", int'(ifa.flush_cnt), 1);
        chk("B timeout1 mem_err", int'(ifb.mem_err), 1);

        // timeout after four wait cycles, one release cycle, then frozen again
        for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        chk("to pre mem_err", int'(ifa.mem_err), 0);
        cyc(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        chk("to release pc_write", int'(ifa.pc_write), 1);
        chk("to mem_err", int'(ifa.mem_err), 1);
        cyc(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        chk("to refreeze", int'(ifa.pc_write), 0);
        idle();
        chk("to sticky", int'(ifa.mem_err), 1);
        chk("to stall_cnt", int'(ifa.stall_cnt), 9);

        // reset in the middle of a wait
        cyc(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        chk("rst mem_err", int'(ifa.mem_err), 0);
        chk("rst stall_cnt", int'(ifa.stall_cnt), 0);
        chk("rst flush_cnt", int'(ifa.flush_cnt), 0);
        chk("rst pc_write", int'(ifa.pc_write), 1);
        // ready without a request is ignored
        cyc(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        chk("post rst ctl", int'(act_ctl[0]), 'b110101);

        // saturation of the 2-bit counters
        for (int k = 0; k < 5; k++) cyc(1'b0, 1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0);
        idle();
        chk("sat B stall_cnt", int'(ifb.stall_cnt), 3);
        chk("sat A stall_cnt", int'(ifa.stall_cnt), 5);
        for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        idle();
        chk("sat B flush_cnt", int'(ifb.flush_cnt), 3);
        chk("sat A flush_cnt", int'(ifa.flush_cnt), 4);
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
